// File: rtl/toggle_event_decoder_pkg.sv
// rtl/toggle_event_decoder_pkg.sv - shared types and defaults for the toggle event decoder
package toggle_event_decoder_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_CNT_W       = 4;
    localparam int DEF_TOTAL_W     = 16;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Wide enough to count the INIT settle period for the largest legal chain.
    localparam int INIT_CNT_W = 3;

endpackage

// File: rtl/toggle_event_decoder_if.sv
// rtl/toggle_event_decoder_if.sv - event delivery handshake between decoder and consumer
interface toggle_event_decoder_if
    import toggle_event_decoder_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             Ev_Valid;
    logic             Ev_Ready;
    logic [CNT_W-1:0] Pending;

    modport master (
        output Ev_Valid,
        output Pending,
        input  Ev_Ready
    );

    modport slave (
        input  Ev_Valid,
        input  Pending,
        output Ev_Ready
    );
endinterface

// File: rtl/toggle_event_decoder_level_sync.sv
// rtl/toggle_event_decoder_level_sync.sv - multi-flop synchroniser for the toggle line
module toggle_event_decoder_level_sync
    import toggle_event_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = MIN_SYNC_STAGES
) (
    input  logic Clk,
    input  logic SR,
    input  logic T_in,
    output logic Level
);
    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge Clk or posedge SR) begin
        if (SR) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], T_in};
        end
    end

    assign Level = chain[SYNC_STAGES-1];
endmodule

// File: rtl/toggle_event_decoder.sv
// rtl/toggle_event_decoder.sv - turns each level flip of a toggle line into a queued event
module toggle_event_decoder
    import toggle_event_decoder_pkg::*;
#(
    parameter int SYNC_STAGES = MIN_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TOTAL_W     = DEF_TOTAL_W
) (
    input  logic                          Clk,
    input  logic                          SR,
    input  logic                          T_in,
    input  logic                          Clr_Ovf,
    toggle_event_decoder_if.master        ev,
    output logic                          Level,
    output logic                          Overflow,
    output logic [TOTAL_W-1:0]            Total
);
    localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(SYNC_STAGES);

    state_t                  state;
    logic [INIT_CNT_W-1:0]   init_cnt;
    logic                    last_level;
    logic                    level_s;
    logic [CNT_W-1:0]        pending_q;
    logic                    overflow_q;
    logic [TOTAL_W-1:0]      total_q;

    logic toggle_edge;
    logic run_edge;
    logic accept;
    logic full;
    logic drop;

    toggle_event_decoder_level_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk   (Clk),
        .SR    (SR),
        .T_in  (T_in),
        .Level (level_s)
    );

    always_comb begin
        toggle_edge = level_s ^ last_level;
        run_edge    = (state == RUN) && toggle_edge;
        accept      = ev.Ev_Valid && ev.Ev_Ready;
        full        = (pending_q == {CNT_W{1'b1}});
        drop        = run_edge && !accept && full;
    end

    // INIT lets last_level settle onto the synchronised line so a level
    // already high at reset release is not mistaken for a flip.
    always_ff @(posedge Clk or posedge SR) begin
        if (SR) begin
            state      <= INIT;
            init_cnt   <= '0;
            last_level <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            total_q    <= '0;
        end else begin
            last_level <= level_s;

            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == INIT_LAST) begin
                        state <= RUN;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase

            if (run_edge && !accept && !full) begin
                pending_q <= pending_q + 1'b1;
            end else if (accept && !run_edge) begin
                pending_q <= pending_q - 1'b1;
            end

            if (drop) begin
                overflow_q <= 1'b1;
            end else if (Clr_Ovf) begin
                overflow_q <= 1'b0;
            end

            // Dropped events still count toward the running total.
            if (run_edge) begin
                total_q <= total_q + 1'b1;
            end
        end
    end

    assign ev.Ev_Valid = (pending_q != '0);
    assign ev.Pending  = pending_q;
    assign Level       = level_s;
    assign Overflow    = overflow_q;
    assign Total       = total_q;
endmodule

// File: tb/tb_toggle_event_decoder.sv
// tb/tb_toggle_event_decoder.sv - scoreboard bench for the toggle event decoder
module tb_toggle_event_decoder;
    logic        clk = 1'b0;
    logic        rst;
    logic        t_in, clr_ovf, level, overflow;
    logic [15:0] total;
    logic        t2, clr2, level2, overflow2;
    logic [3:0]  total2;

    int n_total = 0;
    int n_bad   = 0;
    int sb[$];
    int seq     = 0;

    always #5 clk = ~clk;

    toggle_event_decoder_if #(.CNT_W(4)) evif ();
    toggle_event_decoder_if #(.CNT_W(4)) evif2 ();

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOTAL_W(16)) dut (
        .Clk      (clk),
        .SR       (rst),
        .T_in     (t_in),
        .Clr_Ovf  (clr_ovf),
        .ev       (evif),
        .Level    (level),
        .Overflow (overflow),
        .Total    (total)
    );

    toggle_event_decoder #(.SYNC_STAGES(2), .CNT_W(4), .TOTAL_W(4)) dut_wrap (
        .Clk      (clk),
        .SR       (rst),
        .T_in     (t2),
        .Clr_Ovf  (clr2),
        .ev       (evif2),
        .Level    (level2),
        .Overflow (overflow2),
        .Total    (total2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic flip(input bit expect_event);
        t_in = ~t_in;
        if (expect_event) begin
            sb.push_back(seq);
            seq++;
        end
    endtask

    task automatic do_reset(input logic lvl);
        t_in          = lvl;
        evif.Ev_Ready = 1'b0;
        clr_ovf       = 1'b0;
        rst           = 1'b1;
        step(2);
        rst = 1'b0;
        step(5);
        sb.delete();
    endtask

    // Accept happens on the coming rising edge; inputs are stable by the falling edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && evif.Ev_Valid === 1'b1 && evif.Ev_Ready === 1'b1) begin
            n_total++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_accept: got accept with pending=%0d, want no event queued", evif.Pending);
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst           = 1'b1;
        t_in          = 1'b1;
        clr_ovf       = 1'b0;
        evif.Ev_Ready = 1'b0;
        t2            = 1'b0;
        clr2          = 1'b0;
        evif2.Ev_Ready = 1'b1;

        // Reset state, then release with the line already high
        step(3);
        chk("rst_pending",  32'(evif.Pending), 32'd0);
        chk("rst_valid",    32'(evif.Ev_Valid), 32'd0);
        chk("rst_level",    32'(level), 32'd0);
        chk("rst_total",    32'(total), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        step(10);
        chk("hi_pending", 32'(evif.Pending), 32'd0);
        chk("hi_total",   32'(total), 32'd0);
        chk("hi_valid",   32'(evif.Ev_Valid), 32'd0);
        chk("hi_level",   32'(level), 32'd1);

        // Single event latency and single accept
        do_reset(1'b0);
        flip(1'b1);
        step(2);
        chk("lat_early_valid", 32'(evif.Ev_Valid), 32'd0);
        step(1);
        chk("lat_valid",   32'(evif.Ev_Valid), 32'd1);
        chk("one_pending", 32'(evif.Pending), 32'd1);
        chk("one_total",   32'(total), 32'd1);
        evif.Ev_Ready = 1'b1;
        step(1);
        evif.Ev_Ready = 1'b0;
        chk("one_drained", 32'(evif.Pending), 32'd0);
        chk("one_valid0",  32'(evif.Ev_Valid), 32'd0);
        chk("one_sb",      32'(sb.size()), 32'd0);

        // Burst of five then back-to-back drain
        do_reset(1'b0);
        repeat (5) begin
            flip(1'b1);
            step(3);
        end
        step(2);
        chk("burst_pending", 32'(evif.Pending), 32'd5);
        chk("burst_total",   32'(total), 32'd5);
        evif.Ev_Ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (evif.Ev_Valid !== 1'b1) break;
            cnt++;
            step(1);
        end
        evif.Ev_Ready = 1'b0;
        chk("burst_valid_cycles", 32'(cnt), 32'd5);
        chk("burst_pending0",     32'(evif.Pending), 32'd0);
        chk("burst_sb",           32'(sb.size()), 32'd0);

        // Overflow: 17 flips into a 15-deep counter
        do_reset(1'b0);
        for (int i = 0; i < 17; i++) begin
            flip(i < 15);
            step(3);
        end
        step(1);
        chk("ovf_pending",  32'(evif.Pending), 32'd15);
        chk("ovf_flag",     32'(overflow), 32'd1);
        chk("ovf_total",    32'(total), 32'd17);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        flip(1'b0);
        step(2);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_set_wins",  32'(overflow), 32'd1);
        chk("ovf_total18",   32'(total), 32'd18);
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        chk("ovf_cleared2", 32'(overflow), 32'd0);

        // Edge and accept together while full
        flip(1'b1);
        step(2);
        evif.Ev_Ready = 1'b1;
        step(1);
        evif.Ev_Ready = 1'b0;
        chk("full_sim_pending",  32'(evif.Pending), 32'd15);
        chk("full_sim_overflow", 32'(overflow), 32'd0);
        chk("full_sim_total",    32'(total), 32'd19);
        evif.Ev_Ready = 1'b1;
        step(16);
        evif.Ev_Ready = 1'b0;
        chk("full_drain_pending", 32'(evif.Pending), 32'd0);
        chk("full_drain_sb",      32'(sb.size()), 32'd0);

        // Asynchronous reset with events queued
        do_reset(1'b0);
        repeat (3) begin
            flip(1'b1);
            step(3);
        end
        step(1);
        chk("mid_pending3", 32'(evif.Pending), 32'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_pending",  32'(evif.Pending), 32'd0);
        chk("mid_rst_valid",    32'(evif.Ev_Valid), 32'd0);
        chk("mid_rst_total",    32'(total), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_level",    32'(level), 32'd0);
        sb.delete();
        step(2);
        rst = 1'b0;
        step(10);
        chk("post_rst_pending", 32'(evif.Pending), 32'd0);
        chk("post_rst_total",   32'(total), 32'd0);
        chk("post_rst_level",   32'(level), 32'd1);

        // Total wrap on the narrow-counter instance
        do_reset(1'b0);
        for (int i = 0; i < 16; i++) begin
            t2 = ~t2;
            step(3);
            if (i == 14) chk("wrap_total15", 32'(total2), 32'd15);
        end
        step(1);
        chk("wrap_total0", 32'(total2), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receive-side counterpart of a toggle flip-flop event encoder: a single line flips level once per event, and this block turns each flip back into a discrete event.
- Synchronises the line, detects each level change and queues it as a pending event.
- Events are delivered to a consumer through a valid/ready handshake.
- Also keeps a free-running total event count and a sticky overflow flag.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchroniser chain (legal 2..4)
CNT_W, 4, width of the pending-event counter; maximum 2^CNT_W-1 pending events
TOTAL_W, 16, width of the total-event counter

Ports:
Clk  input  1  rising-edge clock
SR  input  1  reset, asynchronous, active-high
T_in  input  1  toggle-encoded event line, asynchronous to Clk
Ev_Ready  input  1  consumer accepts one event this cycle
Clr_Ovf  input  1  synchronous clear of Overflow
Ev_Valid  output  1  at least one event pending
Pending  output  CNT_W  number of queued events
Level  output  1  synchronised level of T_in
Overflow  output  1  sticky, set when an event was dropped
Total  output  TOTAL_W  count of all detected events, including dropped ones

Behaviour:
- One clock; reset is asynchronous and active-high (Clk, SR).
- Reset values: sync chain all 0, last_level 0, Level 0, Pending 0, Ev_Valid 0, Overflow 0, Total 0, FSM in INIT, init counter 0.
- Synchroniser: T_in passes through SYNC_STAGES flops; the final stage is Level.
- last_level register: loads Level every cycle. edge = Level XOR last_level.
- FSM states:
  - INIT: increments the init counter each cycle. last_level tracks Level, but edge is ignored (no Pending or Total update). After SYNC_STAGES+1 cycles in INIT, go to RUN. Result: a high T_in at reset release does not produce a spurious event.
  - RUN: normal operation. Stays in RUN until SR is asserted.
- Latency: a T_in change (meeting setup) produces edge SYNC_STAGES cycles later. Pending and Ev_Valid update on the following edge, so T_in to Ev_Valid is SYNC_STAGES+1 cycles.
- Handshake:
  - accept = Ev_Valid AND Ev_Ready.
  - Ev_Valid = (Pending != 0), decoded from the Pending register.
  - Ev_Ready while Ev_Valid=0 has no effect.
  - Ev_Valid stays high until every pending event is accepted. The consumer may hold Ev_Ready high and take one event per cycle.
- Pending update in RUN, per cycle:
  - edge only: +1.
  - accept only: -1.
  - edge and accept together: unchanged.
  - neither: unchanged.
- Full boundary: Pending = 2^CNT_W-1 with edge and no accept means the event is dropped, Pending holds and Overflow is set. With a simultaneous accept, Pending stays full and nothing is dropped.
- Overflow: cleared by Clr_Ovf. If Clr_Ovf and a new drop occur in the same cycle, set wins.
- Total: +1 on every edge in RUN, including dropped events. Wraps modulo 2^TOTAL_W with no flag.
- Pulses: two T_in flips closer together than one Clk period may merge and be lost. This is outside the contract; the sender must hold each level for at least 2 Clk periods.
- Reset mid-operation: all pending events are discarded immediately and the FSM returns to INIT. Asserting SR during an accept cycle yields no accept.
- Outputs are registered, except Ev_Valid (a registered-compare decode) and Level (a flop).

Decomposition:
- Shared package:
  - FSM state encoding: INIT=1'b0, RUN=1'b1.
  - Default widths: CNT_W=4, TOTAL_W=16.
  - Minimum SYNC_STAGES=2.
- One natural sub-module, level_sync: parameterised SYNC_STAGES flop chain with async reset, output Level. All other logic lives in toggle_event_decoder.

Test Plan:
- Reset-high start: hold T_in=1 through SR release, wait 10 cycles -> Pending=0, Total=0, Ev_Valid=0, Level=1.
- Single event: after INIT, flip T_in 0->1 with Ev_Ready=0 -> Ev_Valid rises exactly 3 cycles later, Pending=1, Total=1. Pulse Ev_Ready 1 cycle -> Pending=0, Ev_Valid=0.
- Burst and drain: 5 flips spaced 3 cycles apart, Ev_Ready=0 -> Pending=5, Total=5. Hold Ev_Ready=1 -> Ev_Valid high exactly 5 cycles, then Pending=0.
- Overflow: 17 flips with Ev_Ready=0 (CNT_W=4) -> Pending=15, Overflow=1, Total=17. Then Clr_Ovf with no drop -> Overflow=0. Then a drop in the same cycle as Clr_Ovf -> Overflow=1.
- Simultaneous edge and accept at Pending=15 -> Pending stays 15, Overflow stays 0, Total increments.
- Mid-operation reset: Pending=3, assert SR asynchronously between clock edges -> all outputs at reset values immediately. After release with T_in unchanged -> no new events. Wrap check: force Total to 0xFFFF, add one edge -> Total=0x0000.
